fifo_feed_ctrl: RTL and testbench
=================================

Name: fifo_feed_ctrl

Overview:
Sequencer for the 12-byte reg_fifo byte-repacking buffer in the input layer. On start it streams NUM_WORDS 64-bit words from block RAM port B into reg_fifo, and drains reg_fifo as 24-bit (3-pixel) groups over a valid/ready stream toward the 3x3 window builder. It tracks FIFO occupancy itself and never overfills or underreads the FIFO. It also flushes the FIFO at the start of every frame.

Parameters:
ADDR_W, 8, width of BRAM port-B address.
NUM_WORDS, 9, 64-bit words per frame (1..2^ADDR_W); bytes per frame = 8*NUM_WORDS.
BASE_ADDR, 0, first BRAM word address of the frame.

Ports:
clk  in  1  clock, all logic on rising edge
reset_n  in  1  synchronous active-low reset
start  in  1  frame trigger; sampled only in IDLE
busy  out  1  high in RUN and DRAIN
done  out  1  one-cycle pulse at end of frame
enb  out  1  BRAM port-B read enable
addrb  out  ADDR_W  BRAM port-B read address
doutb  in  64  BRAM read data, valid 1 cycle after enb
fifo_rst_n  out  1  drives reg_fifo reset_n (= reset_n AND NOT flush)
fifo_din  out  64  reg_fifo data_in (= doutb)
fifo_push  out  1  reg_fifo push
fifo_pop  out  1  reg_fifo pop
fifo_dout  in  24  reg_fifo data_o
out_data  out  24  group to consumer (= fifo_dout)
out_valid  out  1  group available
out_ready  in  1  consumer accepts

Behaviour:
- Reset (reset_n=0 at clk edge): state=IDLE, occ=0, inflight=0, word_cnt=0, addrb=BASE_ADDR. enb, fifo_push, fifo_pop, busy, done and out_valid are 0. fifo_rst_n=0. Reset mid-frame abandons the frame, with no done pulse.
- Occupancy: occ is a 4-bit byte count, range 0..12. Next value: occ + 8*fifo_push - 3*fifo_pop, applied in the same cycle. Simultaneous push and pop are legal.
- inflight: 1 in the cycle after enb=1. fifo_push = inflight (registered copy of enb). BRAM latency is fixed at 1 cycle.
- Read-issue rule: enb=1 when state=RUN, word_cnt<NUM_WORDS and occ + 8*inflight <= 4. This guarantees occ never exceeds 12 and unread bytes are never overwritten. On issue, addrb and word_cnt both increment in the same cycle.
- addrb is registered and presented with enb. A word issued at cycle t is pushed at t+1 and popable from t+2.
- out_valid = (state in RUN or DRAIN) AND occ>=3. fifo_pop = out_valid AND out_ready.
- out_data = fifo_dout combinationally. While out_valid=1 and out_ready=0, out_data is stable.
- FSM:
  - IDLE: on start=1, go to FLUSH.
  - FLUSH: one cycle. fifo_rst_n=0, occ=0, word_cnt=0, addrb=BASE_ADDR. Then go to RUN.
  - RUN: issue reads per the rule. In the cycle the last word is issued (word_cnt becomes NUM_WORDS), go to DRAIN.
  - DRAIN: when inflight=0 and occ<3, and no pop in that cycle, go to DONE.
  - DONE: done=1 for one cycle, then IDLE.
- start is ignored outside IDLE.
- Tail bytes: (8*NUM_WORDS mod 3) leftover bytes are never emitted. They are discarded by the next FLUSH.
- Groups emitted per frame = floor(8*NUM_WORDS/3).
- Consumer stalls: a stalled consumer (out_ready=0) blocks reads once occ>4. No data is lost or duplicated. Frame ordering is byte-exact: group k = bytes 3k..3k+2 of the word stream, low byte first, with each word's bits [7:0] as byte 0.

Test Plan:
- Reset then idle: reset_n=0 for 2 cycles, start=0 -> all outputs 0 except fifo_rst_n=1 after reset; addrb=BASE_ADDR; no enb.
- Basic frame: NUM_WORDS=3, BRAM[i] = bytes 8i..8i+7 (values 0x00..0x17), out_ready=1 -> 8 groups 0x020100, 0x050403 ... 0x171615; done pulses once; busy falls with done.
- Tail handling: NUM_WORDS=9, out_ready=1 -> 24 groups, last 0x474645; second frame after start re-flushes and its first group is 0x020100 again.
- Backpressure: out_ready=0 for 20 cycles mid-frame -> enb stops with occ<=12; out_data held stable; after release, the sequence continues with no gap or duplicate; occ never exceeds 12.
- Random ready (50% toggle), NUM_WORDS=16 -> 42 groups matching the byte-ordered reference model; tail of 2 bytes dropped.
- Start while busy is ignored; reset_n=0 mid-RUN -> IDLE next cycle, no done; next start produces a correct full frame.

Source files
------------

// File: rtl/fifo_feed_ctrl.sv
// fifo_feed_ctrl: sequencer that feeds the reg_fifo byte-repacking buffer
// from BRAM port B and drains it as 24-bit pixel groups.
//
// Ports:
//   clk, reset_n         clock, synchronous active-low reset
//   start                frame trigger, honoured only in IDLE
//   busy, done           frame in progress / one-cycle end-of-frame pulse
//   enb, addrb, doutb    BRAM port-B read (1-cycle latency)
//   fifo_rst_n           reg_fifo reset (also pulsed low to flush a frame)
//   fifo_din, fifo_push  reg_fifo write side (64-bit words)
//   fifo_pop, fifo_dout  reg_fifo read side (24-bit groups)
//   out_data/valid/ready group stream toward the window builder
module fifo_feed_ctrl #(
    parameter int ADDR_W    = 8,
    parameter int NUM_WORDS = 9,
    parameter int BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              enb,
    output logic [ADDR_W-1:0] addrb,
    input  logic [63:0]       doutb,
    output logic              fifo_rst_n,
    output logic [63:0]       fifo_din,
    output logic              fifo_push,
    output logic              fifo_pop,
    input  logic [23:0]       fifo_dout,
    output logic [23:0]       out_data,
    output logic              out_valid,
    input  logic              out_ready
);

    // Word counter must be able to hold NUM_WORDS itself (up to 2^ADDR_W).
    localparam int CNT_W = ADDR_W + 1;

    localparam logic [CNT_W-1:0]  NUM_CNT   = CNT_W'(NUM_WORDS);
    localparam logic [CNT_W-1:0]  LAST_CNT  = CNT_W'(NUM_WORDS - 1);
    localparam logic [ADDR_W-1:0] ADDR_BASE = ADDR_W'(BASE_ADDR);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FLUSH,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [3:0]        occ_q, occ_d;
    logic              inflight_q, inflight_d;
    logic [CNT_W-1:0]  word_cnt_q, word_cnt_d;
    logic [ADDR_W-1:0] addrb_q, addrb_d;

    logic       active;
    logic       flush;
    logic       issue;
    logic       push;
    logic       pop;
    logic       valid;
    logic       room;
    logic [4:0] committed;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            occ_q      <= 4'd0;
            inflight_q <= 1'b0;
            word_cnt_q <= '0;
            addrb_q    <= ADDR_BASE;
        end else begin
            state_q    <= state_d;
            occ_q      <= occ_d;
            inflight_q <= inflight_d;
            word_cnt_q <= word_cnt_d;
            addrb_q    <= addrb_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        occ_d      = occ_q;
        word_cnt_d = word_cnt_q;
        addrb_d    = addrb_q;
        flush      = 1'b0;
        done       = 1'b0;

        active = (state_q == S_RUN) || (state_q == S_DRAIN);
        valid  = active && (occ_q >= 4'd3);
        pop    = valid && out_ready;
        push   = inflight_q;

        // Bytes already owned by the FIFO, counting a word still in the
        // BRAM pipe. A new 8-byte word only fits when this is <= 4.
        committed = {1'b0, occ_q} + {1'b0, inflight_q, 3'b000};
        room      = (committed <= 5'd4);

        issue = (state_q == S_RUN) && (word_cnt_q < NUM_CNT) && room;

        inflight_d = issue;

        // Push and pop in the same cycle are both applied.
        occ_d = occ_q
              + (push ? 4'd8 : 4'd0)
              - (pop  ? 4'd3 : 4'd0);

        if (issue) begin
            addrb_d    = addrb_q + 1'b1;
            word_cnt_d = word_cnt_q + 1'b1;
        end

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_FLUSH;
                end
            end
            S_FLUSH: begin
                // Clears the FIFO, discarding any tail bytes of the last frame.
                flush      = 1'b1;
                occ_d      = 4'd0;
                word_cnt_d = '0;
                addrb_d    = ADDR_BASE;
                state_d    = S_RUN;
            end
            S_RUN: begin
                if (issue && (word_cnt_q == LAST_CNT)) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                // occ < 3 implies no pop can occur this cycle.
                if (!inflight_q && (occ_q < 4'd3)) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign busy       = active;
    assign enb        = issue;
    assign addrb      = addrb_q;
    assign fifo_rst_n = reset_n & ~flush;
    assign fifo_din   = doutb;
    assign fifo_push  = push;
    assign fifo_pop   = pop;
    assign out_data   = fifo_dout;
    assign out_valid  = valid;

endmodule

// File: tb/tb_fifo_feed_ctrl.sv
// tb_fifo_feed_ctrl: randomized bench with BRAM and reg_fifo models.
// Groups are checked against the byte-ordered frame reference.
module tb_fifo_feed_ctrl;

    localparam int AW   = 8;
    localparam int NW   = 16;
    localparam int BASE = 5;
    localparam int NB   = 8 * NW;
    localparam int NG   = NB / 3;
    localparam int TAIL = NB % 3;

    logic          clk       = 1'b0;
    logic          reset_n   = 1'b0;
    logic          start     = 1'b0;
    logic          busy;
    logic          done;
    logic          enb;
    logic [AW-1:0] addrb;
    logic [63:0]   doutb     = '0;
    logic          fifo_rst_n;
    logic [63:0]   fifo_din;
    logic          fifo_push;
    logic          fifo_pop;
    logic [23:0]   fifo_dout = '0;
    logic [23:0]   out_data;
    logic          out_valid;
    logic          out_ready = 1'b0;

    fifo_feed_ctrl #(
        .ADDR_W   (AW),
        .NUM_WORDS(NW),
        .BASE_ADDR(BASE)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .enb       (enb),
        .addrb     (addrb),
        .doutb     (doutb),
        .fifo_rst_n(fifo_rst_n),
        .fifo_din  (fifo_din),
        .fifo_push (fifo_push),
        .fifo_pop  (fifo_pop),
        .fifo_dout (fifo_dout),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    logic [63:0] mem [0:255];
    logic [7:0]  q [$];

    int n_chk     = 0;
    int n_pass    = 0;
    int gidx      = 0;
    int issued    = 0;
    int done_cnt  = 0;
    int flush_cnt = 0;
    int rdy_mode  = 0;

    bit          p_enb  = 0;
    bit          p_push = 0;
    bit          p_pop  = 0;
    bit          p_rst  = 0;
    logic [AW-1:0] p_addr = '0;
    logic [63:0] p_din  = '0;
    bit          prev_stall = 0;
    logic [23:0] prev_data  = '0;

    task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Group k = frame bytes 3k..3k+2, byte 0 in the low bits.
    function automatic logic [23:0] exp_grp(int k);
        logic [23:0] g;
        logic [63:0] w;
        int          j;
        g = '0;
        for (int i = 0; i < 3; i++) begin
            j = 3 * k + i;
            w = mem[BASE + j / 8];
            g[8*i +: 8] = w[8*(j % 8) +: 8];
        end
        return g;
    endfunction

    // Monitor: sample settled outputs mid-cycle, queue model actions.
    always @(negedge clk) begin
        p_enb  = (enb === 1'b1);
        p_addr = addrb;
        p_push = (fifo_push === 1'b1);
        p_din  = fifo_din;
        p_pop  = (fifo_pop === 1'b1);
        p_rst  = (fifo_rst_n === 1'b1);
        if (reset_n) begin
            if (!fifo_rst_n) begin
                flush_cnt++;
                gidx   = 0;
                issued = 0;
            end
            check("out_valid", out_valid, busy && (q.size() >= 3));
            if (enb) begin
                check("enb_busy", busy, 1);
                check("addrb", addrb, AW'(BASE + issued));
                check("word_lim", issued < NW, 1);
                issued++;
            end
            if (fifo_pop) begin
                check("underread", q.size() >= 3, 1);
                check("grp_lim", gidx < NG, 1);
                if (gidx < NG) check("group", out_data, exp_grp(gidx));
                gidx++;
            end
            if (fifo_push) begin
                check("occ_max", q.size() + 8 - (fifo_pop ? 3 : 0) <= 12, 1);
            end
            if (prev_stall) begin
                check("stall_valid", out_valid, 1);
                check("stall_data", out_data, prev_data);
            end
            if (done) begin
                done_cnt++;
                check("done_busy", busy, 0);
                check("done_groups", gidx, NG);
                check("done_words", issued, NW);
                check("done_tail", q.size(), TAIL);
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
        end else begin
            gidx       = 0;
            issued     = 0;
            prev_stall = 0;
        end
    end

    // BRAM, reg_fifo and consumer models, updated just after each edge.
    always @(posedge clk) begin
        logic [7:0] b0, b1, b2;
        #1;
        if (p_enb) doutb = mem[p_addr];
        if (!p_rst) begin
            q.delete();
        end else begin
            if (p_pop) begin
                repeat (3) if (q.size() > 0) void'(q.pop_front());
            end
            if (p_push) begin
                for (int b = 0; b < 8; b++) q.push_back(p_din[8*b +: 8]);
            end
        end
        b0 = (q.size() > 0) ? q[0] : 8'h00;
        b1 = (q.size() > 1) ? q[1] : 8'h00;
        b2 = (q.size() > 2) ? q[2] : 8'h00;
        fifo_dout = {b2, b1, b0};
        case (rdy_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = 1'($urandom_range(0, 1));
            default: out_ready = 1'b0;
        endcase
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        cyc();
        start = 1'b0;
    endtask

    task automatic wait_done(int budget);
        int d0;
        d0 = done_cnt;
        for (int i = 0; i < budget && done_cnt == d0; i++) cyc();
        check("done_seen", done_cnt - d0, 1);
        @(negedge clk);
        check("done_pulse", done, 0);
        check("idle_busy", busy, 0);
    endtask

    task automatic fill_ramp();
        for (int w = 0; w < NW; w++)
            for (int b = 0; b < 8; b++)
                mem[BASE + w][8*b +: 8] = 8'(8 * w + b);
    endtask

    task automatic fill_rand();
        for (int w = 0; w < NW; w++)
            mem[BASE + w] = {$urandom, $urandom};
    endtask

    initial begin
        int d0;
        int f0;
        for (int i = 0; i < 256; i++) mem[i] = '0;
        rdy_mode = 0;
        cyc();
        cyc();
        reset_n = 1'b1;
        @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_enb", enb, 0);
        check("rst_valid", out_valid, 0);
        check("rst_push", fifo_push, 0);
        check("rst_pop", fifo_pop, 0);
        check("rst_fifo_rst_n", fifo_rst_n, 1);
        check("rst_addrb", addrb, AW'(BASE));
        repeat (3) cyc();
        check("idle_no_flush", flush_cnt, 0);

        // Ramp frame, free-running consumer, then a re-flushed repeat.
        fill_ramp();
        pulse_start();
        wait_done(1000);
        cyc();
        pulse_start();
        wait_done(1000);

        // Consumer stalls for 20 cycles mid-frame.
        fill_rand();
        cyc();
        pulse_start();
        repeat (10) cyc();
        rdy_mode = 2;
        repeat (20) cyc();
        @(negedge clk);
        check("stall_enb", enb, 0);
        check("stall_held", out_valid, 1);
        cyc();
        rdy_mode = 0;
        wait_done(1000);

        // Random ready, random data.
        rdy_mode = 1;
        for (int f = 0; f < 2; f++) begin
            fill_rand();
            cyc();
            pulse_start();
            wait_done(2000);
        end

        // Start while busy must not restart the frame.
        fill_rand();
        cyc();
        f0 = flush_cnt;
        d0 = done_cnt;
        pulse_start();
        repeat (5) cyc();
        pulse_start();
        wait_done(2000);
        repeat (10) cyc();
        check("busy_start_flush", flush_cnt - f0, 1);
        check("busy_start_done", done_cnt - d0, 1);

        // Reset mid-RUN abandons the frame without done.
        fill_rand();
        cyc();
        pulse_start();
        repeat (6) cyc();
        d0 = done_cnt;
        reset_n = 1'b0;
        cyc();
        reset_n = 1'b1;
        @(negedge clk);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_enb", enb, 0);
        check("mid_rst_addrb", addrb, AW'(BASE));
        repeat (20) cyc();
        check("mid_rst_no_done", done_cnt, d0);
        fill_rand();
        pulse_start();
        wait_done(2000);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
